// File: rtl/kbd_queue_if.sv
// Keyboard queue bus: the writer side (keyboard path) and the reader side (KBSR/KBDR registers).
interface kbd_queue_if;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic [2:0]  count;
  logic [15:0] kbsr;
  logic [15:0] kbdr;
  logic        ovf;
  logic        ovf_clr;

  // Driver of pushes, pops and overflow clears
  modport master (
    output wr_en, wr_data, rd_en, ovf_clr,
    input  full, rd_data, empty, count, kbsr, kbdr, ovf
  );

  // The queue itself
  modport slave (
    input  wr_en, wr_data, rd_en, ovf_clr,
    output full, rd_data, empty, count, kbsr, kbdr, ovf
  );
endinterface

// File: rtl/kbd_queue.sv
// kbd_queue: 4-entry x 8-bit first-word-fall-through queue feeding the LC-3 KBSR/KBDR registers.
// Optional sticky overflow flag enabled by defining KBD_QUEUE_OVF_EN.
module kbd_queue (
  input  logic        clk,
  input  logic        reset,
  kbd_queue_if.slave  bus
);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 3;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          full_c;
  logic          empty_c;
  logic          push_acc_c;
  logic          pop_acc_c;
  logic          ovf_bit;

  // Status and handshake acceptance, all derived from the occupancy count
  always_comb begin
    full_c     = (count_q == CW'(DEPTH));
    empty_c    = (count_q == CW'(0));
    // A pop on a full queue frees the slot the push lands in
    push_acc_c = bus.wr_en && (!full_c || bus.rd_en);
    pop_acc_c  = bus.rd_en && !empty_c;
  end

  // Pointer and occupancy update; reset takes priority over any request
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push_acc_c) wptr <= wptr + AW'(1);
      if (pop_acc_c)  rptr <= rptr + AW'(1);
      count_q <= count_q + CW'(push_acc_c) - CW'(pop_acc_c);
    end
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!reset && push_acc_c) mem[wptr] <= bus.wr_data;
  end

`ifdef KBD_QUEUE_OVF_EN
  logic ovf_q;

  // Sticky drop flag; a new drop on the clearing edge keeps it set
  always_ff @(posedge clk) begin
    if (reset)                                    ovf_q <= 1'b0;
    else if (bus.wr_en && full_c && !bus.rd_en)   ovf_q <= 1'b1;
    else if (bus.ovf_clr)                         ovf_q <= 1'b0;
  end

  assign ovf_bit = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign ovf_bit        = 1'b0;
`endif

  // Reader-facing views of the head entry and status
  always_comb begin
    bus.full    = full_c;
    bus.empty   = empty_c;
    bus.count   = count_q;
    bus.rd_data = mem[rptr];
    bus.ovf     = ovf_bit;
    bus.kbsr    = {~empty_c, ovf_bit, 14'b0};
    bus.kbdr    = {8'h00, mem[rptr]};
  end
endmodule

// File: tb/tb_kbd_queue.sv
// Directed self-checking bench for kbd_queue (works with or without KBD_QUEUE_OVF_EN).
module tb_kbd_queue;
`ifdef KBD_QUEUE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [7:0] model_q [$];
  logic [7:0] exp_head;

  kbd_queue_if bus ();

  kbd_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset then idle
    check("rst_empty", 16'(bus.empty), 16'h1);
    check("rst_full",  16'(bus.full),  16'h0);
    check("rst_count", 16'(bus.count), 16'h0);
    check("rst_kbsr",  bus.kbsr,       16'h0000);
    check("rst_ovf",   16'(bus.ovf),   16'h0);

    // Pop on empty is ignored
    pop();
    check("pop_empty_count", 16'(bus.count), 16'h0);

    // Single push then pop
    push(8'h41);
    check("one_rd_data", 16'(bus.rd_data), 16'h0041);
    check("one_kbdr",    bus.kbdr,         16'h0041);
    check("one_kbsr",    bus.kbsr,         16'h8000);
    check("one_count",   16'(bus.count),   16'h1);
    pop();
    check("one_pop_empty", 16'(bus.empty), 16'h1);
    check("one_pop_count", 16'(bus.count), 16'h0);

    // Fill to full, then a dropped push
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    check("fill_full",  16'(bus.full),  16'h1);
    check("fill_count", 16'(bus.count), 16'h4);
    push(8'h45);
    check("drop_count", 16'(bus.count),   16'h4);
    check("drop_full",  16'(bus.full),    16'h1);
    check("drop_head",  16'(bus.rd_data), 16'h0041);
    check("drop_ovf",   16'(bus.ovf),     16'(OVF_ON));
    check("drop_kbsr",  bus.kbsr,         {1'b1, OVF_ON, 14'b0});

    // Clear racing a new drop: set wins; then a plain clear
    bus.ovf_clr = 1'b1;
    push(8'h46);
    check("clr_race_ovf",   16'(bus.ovf),   16'(OVF_ON));
    check("clr_race_count", 16'(bus.count), 16'h4);
    tick();
    bus.ovf_clr = 1'b0;
    check("clr_ovf",  16'(bus.ovf), 16'h0);
    check("clr_kbsr", bus.kbsr,     16'h8000);

    // Drain in order
    check("drain_0", 16'(bus.rd_data), 16'h0041); pop();
    check("drain_1", 16'(bus.rd_data), 16'h0042); pop();
    check("drain_2", 16'(bus.rd_data), 16'h0043); pop();
    check("drain_3", 16'(bus.rd_data), 16'h0044); pop();
    check("drain_empty", 16'(bus.empty), 16'h1);

    // Full queue with simultaneous push and pop
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    bus.rd_en = 1'b1;
    push(8'h55);
    bus.rd_en = 1'b0;
    check("fullrw_count", 16'(bus.count),   16'h4);
    check("fullrw_head",  16'(bus.rd_data), 16'h0042);
    check("fullrw_ovf",   16'(bus.ovf),     16'h0);
    check("fullrw_0", 16'(bus.rd_data), 16'h0042); pop();
    check("fullrw_1", 16'(bus.rd_data), 16'h0043); pop();
    check("fullrw_2", 16'(bus.rd_data), 16'h0044); pop();
    check("fullrw_3", 16'(bus.rd_data), 16'h0055); pop();
    check("fullrw_empty", 16'(bus.empty), 16'h1);

    // Empty queue with simultaneous push and pop: pop ignored
    bus.rd_en = 1'b1;
    push(8'h66);
    bus.rd_en = 1'b0;
    check("emptyrw_count", 16'(bus.count),   16'h1);
    check("emptyrw_data",  16'(bus.rd_data), 16'h0066);
    pop();
    check("emptyrw_drain", 16'(bus.empty), 16'h1);

    // 12 push/pop pairs across several pointer wraps, against a reference queue
    push(8'h70);
    push(8'h71);
    model_q.push_back(8'h70);
    model_q.push_back(8'h71);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] v;
      v = 8'(8'h80 + i);
      exp_head = model_q.pop_front();
      check("wrap_head", 16'(bus.rd_data), 16'(exp_head));
      if (i % 2 == 0) begin
        bus.rd_en = 1'b1;
        push(v);
        bus.rd_en = 1'b0;
      end else begin
        pop();
        push(v);
      end
      model_q.push_back(v);
      check("wrap_count", 16'(bus.count), 16'h2);
    end
    while (model_q.size() > 0) begin
      exp_head = model_q.pop_front();
      check("wrap_tail", 16'(bus.rd_data), 16'(exp_head));
      pop();
    end
    check("wrap_empty", 16'(bus.empty), 16'h1);

    // Reset mid-operation with a push pending
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h99);
    pop();
    check("prerst_count", 16'(bus.count), 16'h3);
    reset       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hAA;
    tick();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    check("midrst_count", 16'(bus.count), 16'h0);
    check("midrst_empty", 16'(bus.empty), 16'h1);
    check("midrst_ovf",   16'(bus.ovf),   16'h0);
    check("midrst_kbsr",  bus.kbsr,       16'h0000);

    // Pointers restart at zero after reset
    push(8'h5A);
    check("postrst_data", 16'(bus.rd_data), 16'h005A);
    check("postrst_count", 16'(bus.count), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
